// File: rtl/mmio_keys_pkg.sv
// Shared register map, field positions and sequencer states for mmio_keys_queue.
package mmio_keys_pkg;

    localparam logic [4:0] ADDR_ROW0   = 5'h00;
    localparam logic [4:0] ADDR_EVENT  = 5'h10;
    localparam logic [4:0] ADDR_STATUS = 5'h11;
    localparam logic [4:0] ADDR_HOLD   = 5'h12;
    localparam logic [4:0] ADDR_CTRL   = 5'h13;

    localparam int unsigned ST_EMPTY     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVERFLOW  = 2;
    localparam int unsigned ST_BADKEY    = 3;
    localparam int unsigned ST_BUSY      = 4;
    localparam int unsigned ST_LEVEL_LSB = 8;

    localparam int unsigned EVT_COL_LSB = 0;
    localparam int unsigned EVT_ROW_LSB = 4;
    localparam int unsigned EVT_PRESS   = 8;
    localparam int unsigned EVT_W       = 9;

    localparam int unsigned CTRL_FLUSH  = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        HOLD
    } seq_state_t;

endpackage

// File: rtl/keys_evt_fifo.sv
// Synchronous event FIFO with show-ahead head; caller is responsible for gating push/pop.
module keys_evt_fifo
    import mmio_keys_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = EVT_W
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign level = count;

endmodule

// File: rtl/mmio_keys_queue.sv
// Avalon-MM keyboard matrix with direct row writes and a timed press/release event queue.
// Optional queue-drained interrupt irq_o is built when KEYS_QUEUE_IRQ_EN is defined.
module mmio_keys_queue
    import mmio_keys_pkg::*;
#(
    parameter int unsigned ROWS         = 10,
    parameter int unsigned COLS         = 8,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned HOLD_DEFAULT = 40
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [4:0]           avs_address_i,
    input  logic                 avs_read_i,
    input  logic                 avs_write_i,
    input  logic [31:0]          avs_writedata_i,
    output logic [31:0]          avs_readdata_o,
    output logic [ROWS*COLS-1:0] keys_o,
    input  logic [3:0]           row_sel_i,
    output logic [COLS-1:0]      col_o
`ifdef KEYS_QUEUE_IRQ_EN
    ,
    output logic                 irq_o
`endif
);

    localparam int unsigned NKEYS = ROWS * COLS;
    localparam int unsigned LW    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_W = $clog2(TICK_DIV) + 16;

    logic [NKEYS-1:0] keys_q, keys_d;
    logic [COLS-1:0]  col_q, col_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [15:0]      hold_q;
    logic             overflow_q, badkey_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    seq_state_t       state_q, state_d;
    logic             irq_en;

    logic             evt_wr, evt_valid, push, pop, flush;
    logic [EVT_W-1:0] head;
    logic             fifo_empty, fifo_full;
    logic [LW-1:0]    level;
    logic [3:0]       head_row, head_col;
    logic             head_press;
    logic             unused_wdata;

    assign unused_wdata = ^avs_writedata_i[31:16];

    assign evt_wr    = avs_write_i && (avs_address_i == ADDR_EVENT);
    assign evt_valid = ({1'b0, avs_writedata_i[EVT_ROW_LSB +: 4]} < 5'(ROWS)) &&
                       ({1'b0, avs_writedata_i[EVT_COL_LSB +: 4]} < 5'(COLS));
    assign flush     = avs_write_i && (avs_address_i == ADDR_CTRL) && avs_writedata_i[CTRL_FLUSH];
    assign push      = evt_wr && evt_valid && !fifo_full && !flush;
    assign pop       = (state_q == APPLY) && !flush;

    assign head_row   = head[EVT_ROW_LSB +: 4];
    assign head_col   = head[EVT_COL_LSB +: 4];
    assign head_press = head[EVT_PRESS];

    keys_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EVT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .din     (avs_writedata_i[EVT_W-1:0]),
        .dout    (head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (level)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE:  if (!fifo_empty) state_d = APPLY;
            APPLY: begin
                state_d = HOLD;
                cnt_d   = CNT_W'(hold_q) * CNT_W'(TICK_DIV);
            end
            // A zero count still spends one cycle here, like a count of one.
            HOLD:  if (cnt_q <= CNT_W'(1)) state_d = IDLE;
                   else cnt_d = cnt_q - CNT_W'(1);
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Event bit first, then a same-cycle direct row write overrides the whole row.
    always_comb begin
        keys_d = keys_q;
        if (state_q == APPLY) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    if (head_row == 4'(r) && head_col == 4'(c)) keys_d[r*COLS+c] = ~head_press;
                end
            end
        end
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (avs_write_i && avs_address_i == ADDR_ROW0 + 5'(r))
                keys_d[r*COLS +: COLS] = avs_writedata_i[COLS-1:0];
        end
        if (flush) keys_d = '1;
    end

    always_comb begin
        col_d = '1;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (row_sel_i == 4'(r)) col_d = keys_q[r*COLS +: COLS];
        end
    end

    always_comb begin
        rdata_d = '0;
        if (avs_read_i) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                if (avs_address_i == ADDR_ROW0 + 5'(r)) rdata_d[COLS-1:0] = keys_q[r*COLS +: COLS];
            end
            case (avs_address_i)
                ADDR_STATUS: begin
                    rdata_d[ST_EMPTY]          = fifo_empty;
                    rdata_d[ST_FULL]           = fifo_full;
                    rdata_d[ST_OVERFLOW]       = overflow_q;
                    rdata_d[ST_BADKEY]         = badkey_q;
                    rdata_d[ST_BUSY]           = (state_q != IDLE);
                    rdata_d[ST_LEVEL_LSB +: 8] = 8'(level);
                end
                ADDR_HOLD: rdata_d[15:0]        = hold_q;
                ADDR_CTRL: rdata_d[CTRL_IRQ_EN] = irq_en;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            keys_q     <= '1;
            col_q      <= '1;
            rdata_q    <= '0;
            hold_q     <= 16'(HOLD_DEFAULT);
            overflow_q <= 1'b0;
            badkey_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            keys_q  <= keys_d;
            col_q   <= col_d;
            rdata_q <= rdata_d;
            if (avs_write_i && avs_address_i == ADDR_HOLD) hold_q <= avs_writedata_i[15:0];
            if (avs_write_i && avs_address_i == ADDR_STATUS) begin
                if (avs_writedata_i[ST_OVERFLOW]) overflow_q <= 1'b0;
                if (avs_writedata_i[ST_BADKEY])   badkey_q   <= 1'b0;
            end
            if (evt_wr && !evt_valid)      badkey_q   <= 1'b1;
            else if (evt_wr && fifo_full)  overflow_q <= 1'b1;
        end
    end

`ifdef KEYS_QUEUE_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (avs_write_i && avs_address_i == ADDR_CTRL) irq_en <= avs_writedata_i[CTRL_IRQ_EN];
            irq_q <= irq_en && fifo_empty && (state_q == IDLE) && !push;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_en = 1'b0;
`endif

    assign keys_o         = keys_q;
    assign col_o          = col_q;
    assign avs_readdata_o = rdata_q;

endmodule

// File: tb/tb_mmio_keys_queue.sv
// Self-checking bench for mmio_keys_queue: register table plus timed event-queue sequences.
module tb_mmio_keys_queue;
    import mmio_keys_pkg::*;

    localparam int unsigned ROWS = 10;
    localparam int unsigned COLS = 8;

    logic                 clk = 1'b0;
    logic                 reset_i;
    logic [4:0]           avs_address_i;
    logic                 avs_read_i;
    logic                 avs_write_i;
    logic [31:0]          avs_writedata_i;
    logic [31:0]          avs_readdata_o;
    logic [ROWS*COLS-1:0] keys_o;
    logic [3:0]           row_sel_i;
    logic [COLS-1:0]      col_o;
`ifdef KEYS_QUEUE_IRQ_EN
    logic                 irq_o;
`endif

    always #5 clk = ~clk;

    mmio_keys_queue #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .FIFO_DEPTH   (16),
        .TICK_DIV     (4),
        .HOLD_DEFAULT (40)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .avs_address_i   (avs_address_i),
        .avs_read_i      (avs_read_i),
        .avs_write_i     (avs_write_i),
        .avs_writedata_i (avs_writedata_i),
        .avs_readdata_o  (avs_readdata_o),
        .keys_o          (keys_o),
        .row_sel_i       (row_sel_i),
        .col_o           (col_o)
`ifdef KEYS_QUEUE_IRQ_EN
        ,
        .irq_o           (irq_o)
`endif
    );

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] wdata;
        bit          do_wr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    sb_t  sb[$];
    sb_t  mon_e;
    vec_t vecs[12];
    int   checks   = 0;
    int   failures = 0;
    logic [ROWS*COLS-1:0] all_ones;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        avs_address_i   = a;
        avs_writedata_i = d;
        avs_write_i     = 1'b1;
        step(1);
        avs_write_i     = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string n);
        sb.push_back('{exp: e, name: n});
        avs_address_i = a;
        avs_read_i    = 1'b1;
        step(1);
        avs_read_i    = 1'b0;
    endtask

    function automatic logic [31:0] evt(input logic p, input int unsigned r, input int unsigned c);
        return {23'b0, p, r[3:0], c[3:0]};
    endfunction

    function automatic vec_t mk(input logic [4:0] a, input logic [31:0] d, input bit w,
                                input logic [31:0] e, input string n);
        vec_t v;
        v.addr = a; v.wdata = d; v.do_wr = w; v.exp = e; v.name = n;
        return v;
    endfunction

    // Read scoreboard: data returns one cycle after the strobe.
    always @(posedge clk) begin
        if (avs_read_i === 1'b1) begin
            #1;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected actual=%0h required=none", avs_readdata_o);
            end else begin
                mon_e = sb.pop_front();
                chk(mon_e.name, 128'(avs_readdata_o), 128'(mon_e.exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        all_ones        = '1;
        reset_i         = 1'b1;
        avs_address_i   = '0;
        avs_read_i      = 1'b0;
        avs_write_i     = 1'b0;
        avs_writedata_i = '0;
        row_sel_i       = '0;

        vecs[0]  = mk(5'h00, 32'h0000_01FE, 1'b1, 32'h0000_00FE, "row0_trunc");
        vecs[1]  = mk(5'h09, 32'h0000_007F, 1'b1, 32'h0000_007F, "row9_last");
        vecs[2]  = mk(5'h0A, 32'h0000_0000, 1'b1, 32'h0000_0000, "row10_unmapped");
        vecs[3]  = mk(5'h0F, 32'h0000_0012, 1'b1, 32'h0000_0000, "gap_unmapped");
        vecs[4]  = mk(5'h12, 32'h0001_2345, 1'b1, 32'h0000_2345, "hold_16bit");
        vecs[5]  = mk(5'h12, 32'h0000_0000, 1'b1, 32'h0000_0000, "hold_zero");
        vecs[6]  = mk(5'h10, 32'h0000_0000, 1'b0, 32'h0000_0000, "event_write_only");
        vecs[7]  = mk(5'h11, 32'h0000_000C, 1'b1, 32'h0000_0001, "status_w1c_idle");
        vecs[8]  = mk(5'h13, 32'h0000_0000, 1'b1, 32'h0000_0000, "ctrl_zero");
        vecs[9]  = mk(5'h1F, 32'h0000_0000, 1'b0, 32'h0000_0000, "top_unmapped");
        vecs[10] = mk(5'h00, 32'h0000_00FF, 1'b1, 32'h0000_00FF, "row0_restore");
        vecs[11] = mk(5'h09, 32'h0000_00FF, 1'b1, 32'h0000_00FF, "row9_restore");

        step(3);
        reset_i = 1'b0;

        chk("rst_keys", 128'(keys_o), 128'(all_ones));
        chk("rst_col", 128'(col_o), 128'hFF);
        chk("rst_rdata", 128'(avs_readdata_o), 128'h0);
`ifdef KEYS_QUEUE_IRQ_EN
        chk("rst_irq", 128'(irq_o), 128'h0);
`endif
        rd(ADDR_HOLD, 32'd40, "rst_hold");
        rd(ADDR_STATUS, 32'h0001, "rst_status");

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end
        chk("table_keys_restored", 128'(keys_o), 128'(all_ones));

        // Direct row write and registered column select.
        row_sel_i = 4'd2;
        wr(5'd2, 32'h0000_00FB);
        chk("keys_row2", 128'(keys_o[23:16]), 128'hFB);
        chk("col_not_yet", 128'(col_o), 128'hFF);
        step(1);
        chk("col_row2", 128'(col_o), 128'hFB);
        row_sel_i = 4'd12;
        step(1);
        chk("col_row_oob", 128'(col_o), 128'hFF);
        wr(5'd2, 32'h0000_00FF);

        // HOLD=1, TICK_DIV=4: press then release of key (3,5).
        wr(ADDR_HOLD, 32'd1);
        wr(ADDR_EVENT, evt(1'b1, 3, 5));
        wr(ADDR_EVENT, evt(1'b0, 3, 5));
        chk("evt_before_apply", 128'(keys_o[29]), 128'h1);
        step(1);
        chk("evt_fall", 128'(keys_o[29]), 128'h0);
        step(5);
        chk("evt_held", 128'(keys_o[29]), 128'h0);
        step(1);
        chk("evt_rise", 128'(keys_o[29]), 128'h1);
        rd(ADDR_STATUS, 32'h0011, "evt_busy");
        step(5);
        rd(ADDR_STATUS, 32'h0001, "evt_idle");

        // HOLD=0: one-cycle hold, last key index in the matrix.
        wr(ADDR_HOLD, 32'd0);
        wr(ADDR_EVENT, evt(1'b1, 9, 7));
        wr(ADDR_EVENT, evt(1'b0, 9, 7));
        chk("h0_before", 128'(keys_o[79]), 128'h1);
        step(1);
        chk("h0_fall", 128'(keys_o[79]), 128'h0);
        step(2);
        chk("h0_held", 128'(keys_o[79]), 128'h0);
        step(1);
        chk("h0_rise", 128'(keys_o[79]), 128'h1);

        // Direct write collides with APPLY on the same row.
        step(3);
        wr(ADDR_EVENT, evt(1'b1, 4, 2));
        step(1);
        wr(5'd4, 32'h0000_00AF);
        chk("collide_row_wins", 128'(keys_o[39:32]), 128'hAF);
        step(3);
        rd(ADDR_STATUS, 32'h0001, "collide_popped");
        wr(5'd4, 32'h0000_00FF);

        // Fill the queue under a long hold; the first event is popped.
        wr(ADDR_HOLD, 32'h0000_FFFF);
        for (int i = 0; i < 17; i++) wr(ADDR_EVENT, evt(1'b1, 0, 0));
        rd(ADDR_STATUS, 32'h0000_1012, "q_full");
        wr(ADDR_EVENT, evt(1'b1, 0, 1));
        rd(ADDR_STATUS, 32'h0000_1016, "q_overflow");
        chk("q_first_applied", 128'(keys_o[1:0]), 128'h2);

        // Flush mid-hold keeps sticky bits.
        wr(ADDR_CTRL, 32'h1);
        chk("flush_keys", 128'(keys_o), 128'(all_ones));
        rd(ADDR_STATUS, 32'h0005, "flush_sticky");
        rd(ADDR_CTRL, 32'h0, "ctrl_selfclear");
        wr(ADDR_STATUS, 32'h4);
        rd(ADDR_STATUS, 32'h0001, "ovf_clear");

        // Bad keys leave the queue unchanged.
        wr(ADDR_EVENT, evt(1'b1, 2, 1));
        wr(ADDR_EVENT, evt(1'b1, 2, 2));
        wr(ADDR_EVENT, evt(1'b1, 2, 3));
        wr(ADDR_EVENT, evt(1'b1, 12, 0));
        rd(ADDR_STATUS, 32'h0218, "badkey_row");
        wr(ADDR_STATUS, 32'h8);
        rd(ADDR_STATUS, 32'h0210, "badkey_clear");
        wr(ADDR_EVENT, evt(1'b1, 0, 8));
        rd(ADDR_STATUS, 32'h0218, "badkey_col");
        wr(ADDR_CTRL, 32'h1);
        rd(ADDR_STATUS, 32'h0009, "flush_keeps_badkey");
        wr(ADDR_STATUS, 32'h8);
        rd(ADDR_STATUS, 32'h0001, "badkey_clear2");

        wr(ADDR_HOLD, 32'd0);
`ifdef KEYS_QUEUE_IRQ_EN
        wr(ADDR_CTRL, 32'h2);
        rd(ADDR_CTRL, 32'h2, "ctrl_irq_en");
        step(1);
        chk("irq_idle_high", 128'(irq_o), 128'h1);
        wr(ADDR_EVENT, evt(1'b1, 6, 1));
        chk("irq_push_low", 128'(irq_o), 128'h0);
        wr(ADDR_EVENT, evt(1'b0, 6, 1));
        step(5);
        chk("irq_drain_low", 128'(irq_o), 128'h0);
        step(1);
        chk("irq_drained", 128'(irq_o), 128'h1);
        wr(ADDR_CTRL, 32'h0);
        step(1);
        chk("irq_disabled", 128'(irq_o), 128'h0);
`else
        wr(ADDR_CTRL, 32'h2);
        rd(ADDR_CTRL, 32'h0, "ctrl_irq_absent");
`endif

        // Reset during a hold releases everything.
        wr(ADDR_HOLD, 32'h0000_FFFF);
        wr(ADDR_EVENT, evt(1'b1, 7, 7));
        step(3);
        chk("pre_reset_pressed", 128'(keys_o[63]), 128'h0);
        reset_i = 1'b1;
        step(1);
        chk("reset_release", 128'(keys_o), 128'(all_ones));
        reset_i = 1'b0;
        rd(ADDR_HOLD, 32'd40, "reset_hold");
        rd(ADDR_STATUS, 32'h0001, "reset_status");

        step(2);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_drain actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
